// File: rtl/panel_input_ctrl.sv
// rtl/panel_input_ctrl.sv - front-panel button debounce and display/address/frequency control
// Optional auto-scan of the RAM display address is enabled by defining PANEL_AUTO_SCAN_EN.
module panel_input_ctrl #(
    parameter logic [19:0] DB_LIMIT    = 20'd1000000,
    parameter logic [26:0] SCAN_PERIOD = 27'd50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_freq,
    output logic [2:0] display,
    output logic [5:0] ram_addr_display,
    output logic       frequency,
    output logic [3:0] btn_evt
);

    logic [3:0]  w_raw;
    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  r_stable;
    logic [19:0] r_cnt [4];
    logic [3:0]  w_rise;
    logic [3:0]  r_evt;
    logic [2:0]  r_display;
    logic [5:0]  r_addr;
    logic        r_freq;
    logic [5:0]  w_addr_next;
    logic        w_scan_step;

    assign w_raw = {btn_freq, btn_down, btn_up, btn_mode};

    // A rising edge of the stable level is known one cycle early, so the event
    // pulse is registered in the same edge that commits the new stable level.
    always_comb begin
        w_rise = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_rise[i] = r_sync2[i] & ~r_stable[i] & (r_cnt[i] == DB_LIMIT - 20'd1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 4'b0000;
            r_sync2  <= 4'b0000;
            r_stable <= 4'b0000;
            r_evt    <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= 20'd0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_evt   <= w_rise;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= 20'd0;
                end else if (r_cnt[i] == DB_LIMIT - 20'd1) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= 20'd0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 20'd1;
                end
            end
        end
    end

`ifdef PANEL_AUTO_SCAN_EN
    logic [26:0] r_scan_cnt;

    // Button moves of the address win over a coincident scan step.
    assign w_scan_step = (r_display == 3'd0) && !(r_evt[1] || r_evt[2])
                         && (r_scan_cnt == SCAN_PERIOD - 27'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_cnt <= 27'd0;
        end else if (r_display != 3'd0 || r_evt[1] || r_evt[2]) begin
            r_scan_cnt <= 27'd0;
        end else if (r_scan_cnt == SCAN_PERIOD - 27'd1) begin
            r_scan_cnt <= 27'd0;
        end else begin
            r_scan_cnt <= r_scan_cnt + 27'd1;
        end
    end
`else
    assign w_scan_step = 1'b0;
`endif

    always_comb begin
        w_addr_next = r_addr;
        if (r_evt[1] && !r_evt[2]) begin
            w_addr_next = r_addr + 6'd1;
        end else if (r_evt[2] && !r_evt[1]) begin
            w_addr_next = r_addr - 6'd1;
        end else if (w_scan_step) begin
            w_addr_next = r_addr + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_display <= 3'd0;
            r_addr    <= 6'd0;
            r_freq    <= 1'b0;
        end else begin
            r_addr <= w_addr_next;
            if (r_evt[0]) begin
                r_display <= (r_display == 3'd6) ? 3'd0 : r_display + 3'd1;
            end
            if (r_evt[3]) begin
                r_freq <= ~r_freq;
            end
        end
    end

    assign display          = r_display;
    assign ram_addr_display = r_addr;
    assign frequency        = r_freq;
    assign btn_evt          = r_evt;

endmodule

// File: tb/tb_panel_input_ctrl.sv
// tb/tb_panel_input_ctrl.sv - directed self-checking bench for panel_input_ctrl
module tb_panel_input_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_freq = 1'b0;
    logic [2:0] display;
    logic [5:0] ram_addr_display;
    logic       frequency;
    logic [3:0] btn_evt;

    int n_checks = 0;
    int n_errors = 0;

    panel_input_ctrl #(
        .DB_LIMIT    (20'd4),
        .SCAN_PERIOD (27'd8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_mode         (btn_mode),
        .btn_up           (btn_up),
        .btn_down         (btn_down),
        .btn_freq         (btn_freq),
        .display          (display),
        .ram_addr_display (ram_addr_display),
        .frequency        (frequency),
        .btn_evt          (btn_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic press(input int idx);
        case (idx)
            0: btn_mode = 1'b1;
            1: btn_up   = 1'b1;
            2: btn_down = 1'b1;
            default: btn_freq = 1'b1;
        endcase
        wait_cycles(8);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_freq = 1'b0;
        wait_cycles(8);
    endtask

    initial begin
        wait_cycles(2);
        chk("reset_display", {29'd0, display}, 32'd0);
        chk("reset_addr", {26'd0, ram_addr_display}, 32'd0);
        chk("reset_freq", {31'd0, frequency}, 32'd0);
        chk("reset_evt", {28'd0, btn_evt}, 32'd0);
        rst = 1'b1;

`ifdef PANEL_AUTO_SCAN_EN
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            chk("scan_step", {26'd0, ram_addr_display}, k / 8);
        end
        btn_mode = 1'b1;
        wait_cycles(7);
        chk("scan_mode_display", {29'd0, display}, 32'd1);
        btn_mode = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("scan_hold_addr", {26'd0, ram_addr_display}, 32'd3);
        end
        chk("scan_hold_display", {29'd0, display}, 32'd1);
`else
        btn_up = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("up_evt", {28'd0, btn_evt}, (k == 6) ? 32'd2 : 32'd0);
            chk("up_addr", {26'd0, ram_addr_display}, (k >= 7) ? 32'd1 : 32'd0);
        end
        btn_up = 1'b0;
        wait_cycles(8);
        chk("up_release_addr", {26'd0, ram_addr_display}, 32'd1);

        btn_mode = 1'b1;
        wait_cycles(3);
        btn_mode = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("glitch_evt", {28'd0, btn_evt}, 32'd0);
            chk("glitch_display", {29'd0, display}, 32'd0);
        end

        for (int p = 1; p <= 7; p++) begin
            press(0);
            chk("mode_cycle", {29'd0, display}, p % 7);
        end

        press(2);
        chk("down_to_0", {26'd0, ram_addr_display}, 32'd0);
        press(2);
        chk("down_wrap", {26'd0, ram_addr_display}, 32'd63);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        wait_cycles(6);
        chk("updown_evt", {28'd0, btn_evt}, 32'd6);
        @(negedge clk);
        chk("updown_hold", {26'd0, ram_addr_display}, 32'd63);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_cycles(8);
        chk("updown_hold_late", {26'd0, ram_addr_display}, 32'd63);

        press(0);
        chk("pre_reset_display", {29'd0, display}, 32'd1);
        btn_freq = 1'b1;
        wait_cycles(4);
        chk("mid_db_freq", {31'd0, frequency}, 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("async_display", {29'd0, display}, 32'd0);
        chk("async_addr", {26'd0, ram_addr_display}, 32'd0);
        chk("async_freq", {31'd0, frequency}, 32'd0);
        chk("async_evt", {28'd0, btn_evt}, 32'd0);
        wait_cycles(3);
        chk("in_reset_freq", {31'd0, frequency}, 32'd0);
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("held_evt", {28'd0, btn_evt}, (k == 6) ? 32'd8 : 32'd0);
            chk("held_freq", {31'd0, frequency}, (k >= 7) ? 32'd1 : 32'd0);
        end
        btn_freq = 1'b0;
        wait_cycles(8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
